// File: rtl/wall_scroller.sv
// Scrolling-wall consumer: fetches a gap height, then erases, moves and redraws
// one wall per frame tick as a one-pixel-per-cycle plot stream.
module wall_scroller #(
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter int         WALL_W      = 8,
    parameter int         GAP_H       = 40,
    parameter int         STEP        = 1,
    parameter logic [2:0] WALL_COLOUR = 3'b010
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       tick,
    input  logic [7:0] height,
    input  logic       height_valid,
    output logic       height_ready,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic [7:0] wall_x,
    output logic [6:0] gap_top
);

    localparam int CW = (WALL_W > 1) ? $clog2(WALL_W) : 1;

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_DRAW  = 3'd1;
    localparam logic [2:0] S_IDLE  = 3'd2;
    localparam logic [2:0] S_ERASE = 3'd3;
    localparam logic [2:0] S_MOVE  = 3'd4;

    localparam logic [7:0]    GAP_MAX  = 8'(SCREEN_H - GAP_H);
    localparam logic [7:0]    WALL_X0  = 8'(SCREEN_W - WALL_W);
    localparam logic [7:0]    X_WRAP   = 8'(SCREEN_W - 1);
    localparam logic [6:0]    ROW_LAST = 7'(SCREEN_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WALL_W - 1);

    // Keeps the whole opening on screen regardless of the requested height.
    function automatic logic [6:0] sat_gap(input logic [7:0] h);
        return (h > GAP_MAX) ? GAP_MAX[6:0] : h[6:0];
    endfunction

    logic [2:0]    state;
    logic [6:0]    row;
    logic [CW-1:0] col;

    logic [8:0] px;
    logic       px_on;
    logic       in_gap;
    logic       scan_last;

    // Column sum is one bit wider so a wrapped wall's overhang is detectable.
    assign px        = {1'b0, wall_x} + 9'(col);
    assign px_on     = px < 9'(SCREEN_W);
    assign in_gap    = (row >= gap_top) && ({1'b0, row} < ({1'b0, gap_top} + 8'(GAP_H)));
    assign scan_last = (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= S_FETCH;
            row          <= '0;
            col          <= '0;
            height_ready <= 1'b0;
            busy         <= 1'b1;
            plot         <= 1'b0;
            x_out        <= '0;
            y_out        <= '0;
            colour       <= '0;
            wall_x       <= WALL_X0;
            gap_top      <= '0;
        end else begin
            // busy lags the state by one edge so it frames the pixel stream exactly
            busy <= (state != S_IDLE);
            plot <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (!height_ready) begin
                        height_ready <= 1'b1;
                    end else if (height_valid) begin
                        gap_top      <= sat_gap(height);
                        height_ready <= 1'b0;
                        state        <= S_DRAW;
                    end
                end
                S_DRAW, S_ERASE: begin
                    x_out  <= px[7:0];
                    y_out  <= row;
                    plot   <= px_on;
                    colour <= ((state == S_ERASE) || in_gap) ? 3'b000 : WALL_COLOUR;
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= scan_last ? 7'd0 : row + 7'd1;
                    end else begin
                        col <= col + CW'(1);
                    end
                    if (scan_last) begin
                        state <= (state == S_DRAW) ? S_IDLE : S_MOVE;
                    end
                end
                S_MOVE: begin
                    if ({1'b0, wall_x} < 9'(STEP)) begin
                        wall_x       <= X_WRAP;
                        height_ready <= 1'b1;
                        state        <= S_FETCH;
                    end else begin
                        wall_x <= wall_x - 8'(STEP);
                        state  <= S_DRAW;
                    end
                end
                S_IDLE: begin
                    if (tick) begin
                        state <= S_ERASE;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule
